// File: rtl/audio_delay_pkg.sv
// Shared types and constants for the audio delay/echo sequencer.
// Sample limits here are for the default sample width.
package audio_delay_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 15;

  // Channel bit placed above the frame pointer on the RAM address
  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MAX = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] SAMPLE_MIN = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_L  = 3'd1,
    S_RD_R  = 3'd2,
    S_CAP_R = 3'd3,
    S_WR_L  = 3'd4,
    S_WR_R  = 3'd5,
    S_OUT   = 3'd6
  } state_e;

endpackage

// File: rtl/audio_sat_add.sv
// Combinational signed adder that clamps to the signed DATA_W range
// instead of wrapping on overflow.
module audio_sat_add #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_sum
);

  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] w_sum;

  // Overflow shows up as the two top bits of the widened sum disagreeing
  function automatic logic signed [DATA_W-1:0] sat_clamp(input logic signed [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? SMIN : SMAX;
    else
      return s[DATA_W-1:0];
  endfunction

  assign w_sum = $signed({i_a[DATA_W-1], i_a}) + $signed({i_b[DATA_W-1], i_b});
  assign o_sum = sat_clamp(w_sum);

endmodule

// File: rtl/audio_delay_sequencer.sv
// Moves one stereo frame per pass from the codec input FIFO to the output FIFO,
// delaying or echoing it through an external single-port RAM used as a ring buffer.
module audio_delay_sequencer
  import audio_delay_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MIX_SHIFT = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     audio_in_available,
  input  logic signed [DATA_W-1:0] left_channel_audio_in,
  input  logic signed [DATA_W-1:0] right_channel_audio_in,
  output logic                     read_audio_in,
  input  logic                     audio_out_allowed,
  output logic signed [DATA_W-1:0] left_channel_audio_out,
  output logic signed [DATA_W-1:0] right_channel_audio_out,
  output logic                     write_audio_out,
  input  logic        [ADDR_W-1:0] delay,
  input  logic                     echo_en,
  output logic        [ADDR_W:0]   ram_addr,
  output logic signed [DATA_W-1:0] ram_wdata,
  output logic                     ram_we,
  input  logic signed [DATA_W-1:0] ram_rdata,
  output logic                     busy
);

  state_e r_state;
  state_e w_state_nxt;

  logic signed [DATA_W-1:0] r_in_l;
  logic signed [DATA_W-1:0] r_in_r;
  logic signed [DATA_W-1:0] r_dl;
  logic signed [DATA_W-1:0] r_out_l;
  logic signed [DATA_W-1:0] r_out_r;
  logic        [ADDR_W-1:0] r_delay;
  logic        [ADDR_W-1:0] r_wr_ptr;
  logic        [ADDR_W-1:0] r_fill_cnt;

  logic                     w_accept;
  logic                     w_have_hist;
  logic        [ADDR_W-1:0] w_rd_ptr;
  logic signed [DATA_W-1:0] w_d_l;
  logic signed [DATA_W-1:0] w_d_r;
  logic signed [DATA_W-1:0] w_sh_l;
  logic signed [DATA_W-1:0] w_sh_r;
  logic signed [DATA_W-1:0] w_mix_l;
  logic signed [DATA_W-1:0] w_mix_r;
  logic signed [DATA_W-1:0] w_nxt_l;
  logic signed [DATA_W-1:0] w_nxt_r;

  // Delayed-sample path: history is treated as silence until the buffer holds `delay` frames
  assign w_rd_ptr    = r_wr_ptr - r_delay;
  assign w_have_hist = (r_fill_cnt >= r_delay);
  assign w_d_l       = w_have_hist ? r_dl : '0;
  assign w_d_r       = w_have_hist ? ram_rdata : '0;
  assign w_sh_l      = w_d_l >>> MIX_SHIFT;
  assign w_sh_r      = w_d_r >>> MIX_SHIFT;

  audio_sat_add #(.DATA_W(DATA_W)) u_mix_l (
    .i_a   (r_in_l),
    .i_b   (w_sh_l),
    .o_sum (w_mix_l)
  );

  audio_sat_add #(.DATA_W(DATA_W)) u_mix_r (
    .i_a   (r_in_r),
    .i_b   (w_sh_r),
    .o_sum (w_mix_r)
  );

  assign w_nxt_l = (r_delay == '0) ? r_in_l : (echo_en ? w_mix_l : w_d_l);
  assign w_nxt_r = (r_delay == '0) ? r_in_r : (echo_en ? w_mix_r : w_d_r);

  assign left_channel_audio_out  = r_out_l;
  assign right_channel_audio_out = r_out_r;
  assign busy                    = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    read_audio_in   = 1'b0;
    write_audio_out = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    unique case (r_state)
      S_IDLE: begin
        // Gating with reset_n keeps the FIFO pop quiet while reset is held
        if (reset_n && audio_in_available && audio_out_allowed) begin
          w_accept      = 1'b1;
          read_audio_in = 1'b1;
          w_state_nxt   = S_RD_L;
        end
      end
      S_RD_L: begin
        ram_addr    = {CH_L, w_rd_ptr};
        w_state_nxt = S_RD_R;
      end
      S_RD_R: begin
        ram_addr    = {CH_R, w_rd_ptr};
        w_state_nxt = S_CAP_R;
      end
      S_CAP_R: begin
        w_state_nxt = S_WR_L;
      end
      S_WR_L: begin
        ram_we      = 1'b1;
        ram_addr    = {CH_L, r_wr_ptr};
        ram_wdata   = echo_en ? r_out_l : r_in_l;
        w_state_nxt = S_WR_R;
      end
      S_WR_R: begin
        ram_we      = 1'b1;
        ram_addr    = {CH_R, r_wr_ptr};
        ram_wdata   = echo_en ? r_out_r : r_in_r;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        write_audio_out = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_delay    <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_out_l    <= '0;
      r_out_r    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_delay <= delay;
      if (r_state == S_CAP_R) begin
        r_out_l <= w_nxt_l;
        r_out_r <= w_nxt_r;
      end
      if (r_state == S_OUT) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (r_fill_cnt != '1)
          r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
      end
    end
  end

  // Sample holding registers: only meaningful inside a pass, so they carry no reset
  always_ff @(posedge CLOCK_50) begin
    if (w_accept) begin
      r_in_l <= left_channel_audio_in;
      r_in_r <= right_channel_audio_in;
    end
    if (r_state == S_RD_R)
      r_dl <= ram_rdata;
  end

endmodule

// File: tb/tb_audio_delay_sequencer.sv
// Directed bench for audio_delay_sequencer with a small 8-frame ring buffer
// and a behavioural single-port synchronous RAM.
module tb_audio_delay_sequencer;
  import audio_delay_pkg::*;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int MS = 1;
  localparam int RAM_WORDS = 1 << (AW + 1);

  logic          CLOCK_50 = 1'b0;
  logic          reset_n;
  logic          audio_in_available;
  logic [DW-1:0] left_channel_audio_in;
  logic [DW-1:0] right_channel_audio_in;
  logic          read_audio_in;
  logic          audio_out_allowed;
  logic [DW-1:0] left_channel_audio_out;
  logic [DW-1:0] right_channel_audio_out;
  logic          write_audio_out;
  logic [AW-1:0] delay;
  logic          echo_en;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_delay_sequencer #(.DATA_W(DW), .ADDR_W(AW), .MIX_SHIFT(MS)) dut (
    .CLOCK_50                (CLOCK_50),
    .reset_n                 (reset_n),
    .audio_in_available      (audio_in_available),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .read_audio_in           (read_audio_in),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .write_audio_out         (write_audio_out),
    .delay                   (delay),
    .echo_en                 (echo_en),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_we                  (ram_we),
    .ram_rdata               (ram_rdata),
    .busy                    (busy)
  );

  // RAM model; starts filled with a marker so ungated reads of stale data show up
  logic [DW-1:0] mem [0:RAM_WORDS-1];
  logic          ram_poison;
  always @(posedge CLOCK_50) begin
    if (ram_poison) begin
      for (int i = 0; i < RAM_WORDS; i++) mem[i] <= 32'hDEADBEEF;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            rst;
    logic [AW-1:0] dly;
    bit            echo;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] el;
    logic [DW-1:0] er;
  } vec_t;

  vec_t vt [11];

  task automatic apply_reset();
    @(negedge CLOCK_50);
    reset_n            = 1'b0;
    audio_in_available = 1'b0;
    audio_out_allowed  = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  // Pushes one frame through; returns with the bench at the negedge of the OUT cycle
  task automatic run_frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input logic [AW-1:0] dly, input bit echo,
                           input logic [DW-1:0] el, input logic [DW-1:0] er,
                           output logic [AW:0] wr_addr);
    int guard;
    guard   = 0;
    wr_addr = '0;
    while (busy && guard < 20) begin
      @(negedge CLOCK_50);
      guard++;
    end
    check($sformatf("%s_idle_wait", tag), {31'd0, busy}, 32'd0);
    left_channel_audio_in  = l;
    right_channel_audio_in = r;
    delay                  = dly;
    echo_en                = echo;
    audio_in_available     = 1'b1;
    audio_out_allowed      = 1'b1;
    #1;
    check($sformatf("%s_read_pulse", tag), {31'd0, read_audio_in}, 32'd1);
    @(posedge CLOCK_50);
    #1;
    audio_in_available     = 1'b0;
    left_channel_audio_in  = 32'h5A5A5A5A;
    right_channel_audio_in = 32'hA5A5A5A5;
    delay                  = dly + AW'(1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLOCK_50);
      check($sformatf("%s_wr_out_t%0d", tag, k), {31'd0, write_audio_out}, {31'd0, (k == 6)});
      check($sformatf("%s_ram_we_t%0d", tag, k), {31'd0, ram_we}, {31'd0, (k == 4 || k == 5)});
      if (k == 4) wr_addr = ram_addr;
    end
    check($sformatf("%s_left", tag), left_channel_audio_out, el);
    check($sformatf("%s_right", tag), right_channel_audio_out, er);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW:0] wa;
    int          bad;

    vt[0]  = '{1'b1, 3'd0, 1'b0, 32'h00001000, 32'hFFFFF000, 32'h00001000, 32'hFFFFF000};
    vt[1]  = '{1'b1, 3'd3, 1'b0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
    vt[2]  = '{1'b0, 3'd3, 1'b0, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0};
    vt[3]  = '{1'b0, 3'd3, 1'b0, 32'd3, 32'hFFFFFFFD, 32'd0, 32'd0};
    vt[4]  = '{1'b0, 3'd3, 1'b0, 32'd4, 32'hFFFFFFFC, 32'd1, 32'hFFFFFFFF};
    vt[5]  = '{1'b0, 3'd3, 1'b0, 32'd5, 32'hFFFFFFFB, 32'd2, 32'hFFFFFFFE};
    vt[6]  = '{1'b1, 3'd1, 1'b1, 32'h7FFFFFF0, 32'h00000100, 32'h7FFFFFF0, 32'h00000100};
    vt[7]  = '{1'b0, 3'd1, 1'b1, 32'h7FFFFFF0, 32'h00000100, SAMPLE_MAX, 32'h00000180};
    vt[8]  = '{1'b1, 3'd1, 1'b1, 32'h80000010, 32'hFFFFFF00, 32'h80000010, 32'hFFFFFF00};
    vt[9]  = '{1'b0, 3'd1, 1'b1, 32'h80000010, 32'hFFFFFF00, SAMPLE_MIN, 32'hFFFFFE80};
    vt[10] = '{1'b1, 3'd0, 1'b1, 32'h12345678, 32'h87654321, 32'h12345678, 32'h87654321};

    // Reset state, with the FIFO handshake inputs deliberately active
    reset_n                = 1'b0;
    ram_poison             = 1'b1;
    audio_in_available     = 1'b1;
    audio_out_allowed      = 1'b1;
    left_channel_audio_in  = 32'h11111111;
    right_channel_audio_in = 32'h22222222;
    delay                  = '0;
    echo_en                = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    check("rst_read", {31'd0, read_audio_in}, 32'd0);
    check("rst_write", {31'd0, write_audio_out}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {28'd0, ram_addr}, 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_left", left_channel_audio_out, 32'd0);
    check("rst_right", right_channel_audio_out, 32'd0);
    ram_poison         = 1'b0;
    audio_in_available = 1'b0;
    audio_out_allowed  = 1'b0;
    reset_n            = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vt[i].rst) apply_reset();
      run_frame($sformatf("vec%0d", i), vt[i].l, vt[i].r, vt[i].dly, vt[i].echo,
                vt[i].el, vt[i].er, wa);
    end

    // Back-pressure: frame available but no room downstream
    apply_reset();
    audio_in_available = 1'b1;
    audio_out_allowed  = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK_50);
      if (read_audio_in !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("bp_stall_cycles", bad, 32'd0);
    run_frame("bp_release", 32'h00000042, 32'hFFFFFFBE, 3'd0, 1'b0, 32'h00000042, 32'hFFFFFFBE, wa);

    // Wrap: delay 7 on an 8-frame buffer
    apply_reset();
    for (int n = 1; n <= 20; n++) begin
      run_frame($sformatf("wrap%0d", n), n, 32'h100 + n, 3'd7, 1'b0,
                (n > 7) ? 32'(n - 7) : 32'd0, (n > 7) ? 32'(32'h100 + n - 7) : 32'd0, wa);
      check($sformatf("wrap%0d_wr_addr", n), {28'd0, wa}, 32'((n - 1) % 8));
    end

    // Reset in the middle of a pass
    apply_reset();
    run_frame("mid_pre0", 32'h0A, 32'h0B, 3'd0, 1'b0, 32'h0A, 32'h0B, wa);
    run_frame("mid_pre1", 32'h0C, 32'h0D, 3'd0, 1'b0, 32'h0C, 32'h0D, wa);
    check("mid_pre1_wr_addr", {28'd0, wa}, 32'd1);
    @(negedge CLOCK_50);
    left_channel_audio_in  = 32'h0E;
    right_channel_audio_in = 32'h0F;
    delay                  = '0;
    audio_in_available     = 1'b1;
    audio_out_allowed      = 1'b1;
    @(posedge CLOCK_50);
    #1;
    audio_in_available = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    check("mid_we_before", {31'd0, ram_we}, 32'd1);
    reset_n            = 1'b0;
    audio_in_available = 1'b1;
    #1;
    check("mid_we_after", {31'd0, ram_we}, 32'd0);
    check("mid_write_after", {31'd0, write_audio_out}, 32'd0);
    check("mid_read_after", {31'd0, read_audio_in}, 32'd0);
    check("mid_busy_after", {31'd0, busy}, 32'd0);
    check("mid_left_after", left_channel_audio_out, 32'd0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLOCK_50);
      if (ram_we !== 1'b0 || write_audio_out !== 1'b0 || read_audio_in !== 1'b0) bad++;
    end
    check("mid_quiet_cycles", bad, 32'd0);
    audio_in_available = 1'b0;
    reset_n            = 1'b1;
    run_frame("mid_post", 32'h33, 32'h44, 3'd0, 1'b0, 32'h33, 32'h44, wa);
    check("mid_post_wr_addr", {28'd0, wa}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
